mux8t1_8: RTL and testbench
===========================

MUX8T1_8 -- requirements
Module: mux8t1_8

Interface
REQ-001 Parameter WIDTH, default 8: data width of every input and of o; only 8 is required to be supported.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sel  input  3  select index, 0..7.
REQ-005 x0  input  8  data input, chosen when sel=0.
REQ-006 x1  input  8  data input, chosen when sel=1.
REQ-007 x2  input  8  data input, chosen when sel=2.
REQ-008 x3  input  8  data input, chosen when sel=3.
REQ-009 x4  input  8  data input, chosen when sel=4.
REQ-010 x5  input  8  data input, chosen when sel=5.
REQ-011 x6  input  8  data input, chosen when sel=6.
REQ-012 x7  input  8  data input, chosen when sel=7.
REQ-013 o  output  8  registered selected data.
REQ-014 par  output  1  registered even parity of o; present only with MUX8T1_8_PARITY_EN.

Function
REQ-015 On each rising clk edge with rst=0, o SHALL load x[sel], where x[n] is input xn; latency exactly 1 cycle from sel/data sampled to o.
REQ-016 All 8 sel codes SHALL be valid; no out-of-range case, no default-to-zero path.
REQ-017 A data change on the selected input SHALL appear on o after 1 edge; changes on unselected inputs SHALL NOT affect o.
REQ-018 sel changing every cycle SHALL produce a new selection every cycle, no bubble or hold.
REQ-019 o SHALL be bit-exact: no inversion, reordering or width change; bit i of o comes from bit i of the selected input.
REQ-020 o SHALL hold its value between edges; no combinational path from inputs to o.

Reset
REQ-021 With rst=1 at a rising edge, o SHALL become 8'h00 (and par 0), overriding selection.
REQ-022 rst asserted mid-operation SHALL clear o on that same edge; first edge with rst=0 SHALL load x[sel] normally.
REQ-023 rst SHALL have no asynchronous effect; between edges o is unchanged by rst.

Configuration
REQ-024 Macro MUX8T1_8_PARITY_EN: when defined, output par SHALL exist and equal XOR of all bits of the value being loaded into o, registered on the same edge (par = ^o at all times); when undefined, par port and its register SHALL be absent and o behaviour unchanged.

Structure
REQ-025 Package mux8t1_8_pkg SHALL hold WIDTH (8), N_IN (8), SEL_W (3) and a data-word typedef of WIDTH bits.
REQ-026 One sub-module, mux8t1_1, SHALL implement a 1-bit 8:1 combinational mux (inputs: 8 bits, sel[2:0]; output: 1 bit); mux8t1_8 SHALL instantiate it WIDTH times, one per bit slice, followed by the output register.

Verification
REQ-027 Reset: rst=1 for 2 edges with x0..x7=00,11,22,33,44,55,66,77, sel=3 -> o=8'h00, par=0.
REQ-028 Sweep: x0..x7=00,11,22,33,44,55,66,77; sel=0..7 held 10 cycles each -> o=8'h00,11,22,33,44,55,66,77 respectively, each valid 1 edge after sel change.
REQ-029 Back-to-back: sel changes every cycle 7,0,5,2 -> o sequence 77,00,55,22 delayed by 1 cycle.
REQ-030 Isolation: sel=4, change x3 to A5 -> o stays 44; change x4 to 5A -> o=5A next edge.
REQ-031 Mid-operation reset: sel=6 streaming, rst=1 for one edge -> o=00 that edge, o=66 the edge after rst deasserts.
REQ-032 Parity (macro defined): sel selects 8'h07 -> par=1; selects 8'h11 -> par=0, aligned with o.

Source files
------------

// File: rtl/mux8t1_8_pkg.sv
// Shared constants, types and the parity helper for the registered 8:1 byte mux.
package mux8t1_8_pkg;

    localparam int WIDTH = 8;
    localparam int N_IN  = 8;
    localparam int SEL_W = 3;

    typedef logic [WIDTH-1:0] data_t;
    typedef logic [SEL_W-1:0] sel_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_par(input data_t d);
        return ^d;
    endfunction

endpackage : mux8t1_8_pkg

// File: rtl/mux8t1_1.sv
// One bit slice of the selector: picks d[sel] out of eight candidate bits.
module mux8t1_1
    import mux8t1_8_pkg::*;
(
    input  logic [N_IN-1:0]  d,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    // Every sel code addresses a real input, so a direct index needs no fallback.
    always_comb begin
        y = d[sel];
    end

endmodule : mux8t1_1

// File: rtl/mux8t1_8.sv
// Registered 8:1 mux of WIDTH-bit words built from per-bit mux8t1_1 slices.
// Define MUX8T1_8_PARITY_EN to add the registered even-parity output par.
module mux8t1_8
#(
    parameter int WIDTH = mux8t1_8_pkg::WIDTH
)
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [mux8t1_8_pkg::SEL_W-1:0]  sel,
    input  logic [WIDTH-1:0]                x0,
    input  logic [WIDTH-1:0]                x1,
    input  logic [WIDTH-1:0]                x2,
    input  logic [WIDTH-1:0]                x3,
    input  logic [WIDTH-1:0]                x4,
    input  logic [WIDTH-1:0]                x5,
    input  logic [WIDTH-1:0]                x6,
    input  logic [WIDTH-1:0]                x7,
    output logic [WIDTH-1:0]                o
`ifdef MUX8T1_8_PARITY_EN
    ,
    output logic                            par
`endif
);

    import mux8t1_8_pkg::*;

    logic [WIDTH-1:0] mux_s;
    logic [WIDTH-1:0] o_r;

    // Slice i gathers bit i of every input so bit order is preserved end to end.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic [N_IN-1:0] col_s;

        assign col_s = {x7[i], x6[i], x5[i], x4[i], x3[i], x2[i], x1[i], x0[i]};

        mux8t1_1 u_bit (
            .d   (col_s),
            .sel (sel),
            .y   (mux_s[i])
        );
    end

    // Output register: synchronous clear wins over the selected data.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_r <= {WIDTH{1'b0}};
        end else begin
            o_r <= mux_s;
        end
    end

    assign o = o_r;

`ifdef MUX8T1_8_PARITY_EN
    logic par_r;

    // Parity is taken from the word being loaded so it lines up with o.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r <= 1'b0;
        end else begin
            par_r <= even_par(mux_s);
        end
    end

    assign par = par_r;
`endif

endmodule : mux8t1_8

// File: tb/tb_mux8t1_8.sv
// Table-driven and randomized bench for mux8t1_8 (parity checked when MUX8T1_8_PARITY_EN is set).
module tb_mux8t1_8;

    typedef struct packed {
        logic        rst;
        logic [2:0]  sel;
        logic [63:0] xs;     // x0 in [7:0] ... x7 in [63:56]
        logic [7:0]  exp_o;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] sel;
    logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic [7:0] o;
`ifdef MUX8T1_8_PARITY_EN
    logic       par;
`endif

    int checks = 0;
    int errors = 0;

    vec_t       vecs[$];
    logic [7:0] prev_exp;
    logic       have_prev;

    mux8t1_8 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .sel (sel),
        .x0  (x0),
        .x1  (x1),
        .x2  (x2),
        .x3  (x3),
        .x4  (x4),
        .x5  (x5),
        .x6  (x6),
        .x7  (x7),
        .o   (o)
`ifdef MUX8T1_8_PARITY_EN
        ,
        .par (par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] s, input logic [63:0] xs, input logic [7:0] e);
        vec_t v;
        v.rst = r;
        v.sel = s;
        v.xs = xs;
        v.exp_o = e;
        vecs.push_back(v);
    endtask

    // Drive one vector after an edge, confirm o holds until the next edge, then check the load.
    task automatic apply(input vec_t v, input string name);
        rst = v.rst;
        sel = v.sel;
        x0 = v.xs[7:0];
        x1 = v.xs[15:8];
        x2 = v.xs[23:16];
        x3 = v.xs[31:24];
        x4 = v.xs[39:32];
        x5 = v.xs[47:40];
        x6 = v.xs[55:48];
        x7 = v.xs[63:56];
        @(negedge clk);
        if (have_prev) check8({name, "_hold"}, o, prev_exp);
        @(posedge clk);
        #1;
        check8(name, o, v.exp_o);
`ifdef MUX8T1_8_PARITY_EN
        check8({name, "_par"}, {7'd0, par}, {7'd0, ^v.exp_o});
`endif
        prev_exp = v.exp_o;
        have_prev = 1'b1;
    endtask

    initial begin
        logic [63:0] base;
        logic [63:0] xs;
        logic [7:0]  xa [8];
        logic [2:0]  s;
        logic        r;
        logic [7:0]  e;
        vec_t        v;

        have_prev = 1'b0;
        prev_exp = 8'h00;
        rst = 1'b1;
        sel = 3'd0;
        {x0, x1, x2, x3, x4, x5, x6, x7} = 64'd0;
        @(posedge clk);
        #1;

        base = 64'h7766554433221100;

        // Reset held two edges with data present.
        add(1'b1, 3'd3, base, 8'h00);
        add(1'b1, 3'd3, base, 8'h00);
        // Sweep every sel code, ten cycles each.
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 10; c++) begin
                add(1'b0, 3'(k), base, 8'(8'h11 * k));
            end
        end
        // Back-to-back selection changes.
        add(1'b0, 3'd7, base, 8'h77);
        add(1'b0, 3'd0, base, 8'h00);
        add(1'b0, 3'd5, base, 8'h55);
        add(1'b0, 3'd2, base, 8'h22);
        // Isolation of unselected inputs.
        xs = base;
        add(1'b0, 3'd4, xs, 8'h44);
        xs[31:24] = 8'hA5;
        add(1'b0, 3'd4, xs, 8'h44);
        xs[39:32] = 8'h5A;
        add(1'b0, 3'd4, xs, 8'h5A);
        // Mid-operation reset while streaming sel=6.
        add(1'b0, 3'd6, base, 8'h66);
        add(1'b0, 3'd6, base, 8'h66);
        add(1'b1, 3'd6, base, 8'h00);
        add(1'b0, 3'd6, base, 8'h66);
        // Parity words 07 (odd count) and 11 (even count).
        xs = base;
        xs[23:16] = 8'h07;
        add(1'b0, 3'd2, xs, 8'h07);
        add(1'b0, 3'd1, xs, 8'h11);
        // Single-bit walk to catch any bit reordering.
        for (int b = 0; b < 8; b++) begin
            xs = 64'hFFFF_FFFF_FFFF_FFFF;
            xs[15:8] = 8'(1 << b);
            add(1'b0, 3'd1, xs, 8'(1 << b));
        end

        foreach (vecs[i]) apply(vecs[i], "table");

        // Randomized traffic against an array-lookup reference model.
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 8; j++) xa[j] = 8'($urandom_range(0, 255));
            s = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 15) == 0);
            e = r ? 8'h00 : xa[s];
            v.rst = r;
            v.sel = s;
            v.xs = {xa[7], xa[6], xa[5], xa[4], xa[3], xa[2], xa[1], xa[0]};
            v.exp_o = e;
            apply(v, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux8t1_8
